// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: bus width, sequencer
// states and the round-robin pick.
package memory_bus_arbiter_pkg;

    localparam int unsigned BusWidth = 32;
    localparam int unsigned CntWidth = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Two requesters: a lone requester wins, contention goes to the port not served last.
    function automatic logic pick_port(input logic req0, input logic req1,
                                       input logic last_grant);
        if (req0 && req1) begin
            return !last_grant;
        end
        return req1;
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// One master's request/response channel to the shared memory bus arbiter.
interface memory_bus_arbiter_if;

    logic                                         req;
    logic                                         we;
    logic [memory_bus_arbiter_pkg::BusWidth-1:0]  addr;
    logic [memory_bus_arbiter_pkg::BusWidth-1:0]  wdata;
    logic [memory_bus_arbiter_pkg::BusWidth-1:0]  rdata;
    logic                                         ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );

endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter and one-transaction-at-a-time sequencer for the shared memory bus;
// absorbs the fixed memory read latency and returns data with a one-cycle ack.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    memory_bus_arbiter_if.slave m0,
    memory_bus_arbiter_if.slave m1,
    output logic                memory_read,
    output logic                memory_write,
    output logic [BusWidth-1:0] address,
    output logic [BusWidth-1:0] write_data,
    input  logic [BusWidth-1:0] read_data,
    output logic                grant,
    output logic                busy
);

    localparam logic [CntWidth-1:0] LatCnt = CntWidth'(MEM_LATENCY);

    logic [1:0]          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic [BusWidth-1:0] address_q, address_d;
    logic [BusWidth-1:0] write_data_q, write_data_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [BusWidth-1:0] rdata0_q, rdata0_d;
    logic [BusWidth-1:0] rdata1_q, rdata1_d;
    logic                pick;
    logic                capture;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
        pick         = pick_port(m0.req, m1.req, last_grant_q);

        unique case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    we_d         = pick ? m1.we    : m0.we;
                    address_d    = pick ? m1.addr  : m0.addr;
                    write_data_d = pick ? m1.wdata : m0.wdata;
                    cnt_d        = LatCnt;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // cnt holds the number of WAIT cycles still to spend before data is valid.
                if (we_q) begin
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= CntWidth'(1)) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (capture) begin
            if (grant_q) begin
                rdata1_d = read_data;
            end else begin
                rdata0_d = read_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        memory_read  = (state_q == ACCESS) && !we_q;
        memory_write = (state_q == ACCESS) && we_q;
        address      = address_q;
        write_data   = write_data_q;
        grant        = grant_q;
        busy         = (state_q != IDLE);
        m0.rdata     = rdata0_q;
        m1.rdata     = rdata1_q;
        m0.ack       = (state_q == DONE) && !grant_q;
        m1.ack       = (state_q == DONE) && grant_q;
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter at MEM_LATENCY 1 (main), 0 and 3, each with a
// latency-accurate memory model that drives garbage outside the valid data window.
module tb_memory_bus_arbiter;
    import memory_bus_arbiter_pkg::*;

    localparam logic [31:0] Bad = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Main DUT, MEM_LATENCY = 1
    memory_bus_arbiter_if m0_if ();
    memory_bus_arbiter_if m1_if ();
    logic        mr, mw, grant, busy;
    logic [31:0] addr, wd, rd;
    logic        v1_q = 1'b0;
    logic [31:0] d1_q = '0;

    memory_bus_arbiter #(.MEM_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
        .memory_read(mr), .memory_write(mw), .address(addr), .write_data(wd),
        .read_data(rd), .grant(grant), .busy(busy)
    );

    always @(posedge clk) begin
        v1_q <= mr;
        d1_q <= mem_f(addr);
    end
    assign rd = v1_q ? d1_q : Bad;

    // MEM_LATENCY = 0
    memory_bus_arbiter_if a0_if ();
    memory_bus_arbiter_if a1_if ();
    logic        z_mr, z_mw, z_grant, z_busy;
    logic [31:0] z_addr, z_wd, z_rd;

    memory_bus_arbiter #(.MEM_LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset), .m0(a0_if), .m1(a1_if),
        .memory_read(z_mr), .memory_write(z_mw), .address(z_addr), .write_data(z_wd),
        .read_data(z_rd), .grant(z_grant), .busy(z_busy)
    );
    assign z_rd = z_mr ? mem_f(z_addr) : Bad;

    // MEM_LATENCY = 3
    memory_bus_arbiter_if b0_if ();
    memory_bus_arbiter_if b1_if ();
    logic        t_mr, t_mw, t_grant, t_busy;
    logic [31:0] t_addr, t_wd, t_rd;
    logic        v3_q [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] d3_q [3] = '{32'h0, 32'h0, 32'h0};

    memory_bus_arbiter #(.MEM_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset), .m0(b0_if), .m1(b1_if),
        .memory_read(t_mr), .memory_write(t_mw), .address(t_addr), .write_data(t_wd),
        .read_data(t_rd), .grant(t_grant), .busy(t_busy)
    );

    always @(posedge clk) begin
        v3_q[0] <= t_mr;
        d3_q[0] <= mem_f(t_addr);
        for (int i = 1; i < 3; i++) begin
            v3_q[i] <= v3_q[i-1];
            d3_q[i] <= d3_q[i-1];
        end
    end
    assign t_rd = v3_q[2] ? d3_q[2] : Bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          t;
        logic        exp_g;
        logic [31:0] exp_a;

        m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
        a0_if.req = 0; a0_if.we = 0; a0_if.addr = '0; a0_if.wdata = '0;
        a1_if.req = 0; a1_if.we = 0; a1_if.addr = '0; a1_if.wdata = '0;
        b0_if.req = 0; b0_if.we = 0; b0_if.addr = '0; b0_if.wdata = '0;
        b1_if.req = 0; b1_if.we = 0; b1_if.addr = '0; b1_if.wdata = '0;

        step;
        step;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wd, 0);
        chk("rst_mread", mr, 0);
        chk("rst_mwrite", mw, 0);
        chk("rst_ack0", m0_if.ack, 0);
        chk("rst_rdata0", m0_if.rdata, 0);
        chk("rst_rdata1", m1_if.rdata, 0);
        reset = 0;
        step;

        // Single read by m0
        m0_if.we = 0; m0_if.addr = 32'h0000_0010; m0_if.req = 1;
        step;
        chk("rd_access_mread", mr, 1);
        chk("rd_access_mwrite", mw, 0);
        chk("rd_access_addr", addr, 32'h10);
        chk("rd_access_grant", grant, 0);
        chk("rd_access_busy", busy, 1);
        step;
        chk("rd_wait_mread", mr, 0);
        chk("rd_wait_ack", m0_if.ack, 0);
        step;
        chk("rd_done_ack0", m0_if.ack, 1);
        chk("rd_done_ack1", m1_if.ack, 0);
        chk("rd_done_rdata", m0_if.rdata, 32'hDEAD_BEEF);
        m0_if.req = 0;
        step;
        chk("rd_idle_ack", m0_if.ack, 0);
        chk("rd_idle_busy", busy, 0);

        // Single write by m1
        m1_if.we = 1; m1_if.addr = 32'h0000_0FFC; m1_if.wdata = 32'h1234_5678; m1_if.req = 1;
        step;
        chk("wr_access_mwrite", mw, 1);
        chk("wr_access_mread", mr, 0);
        chk("wr_access_addr", addr, 32'hFFC);
        chk("wr_access_wdata", wd, 32'h1234_5678);
        chk("wr_access_grant", grant, 1);
        step;
        chk("wr_done_ack1", m1_if.ack, 1);
        chk("wr_done_ack0", m0_if.ack, 0);
        chk("wr_done_rdata0", m0_if.rdata, 32'hDEAD_BEEF);
        chk("wr_done_rdata1", m1_if.rdata, 0);
        m1_if.req = 0;
        step;
        chk("wr_idle_addr_hold", addr, 32'hFFC);
        chk("wr_idle_mwrite", mw, 0);

        // Contention: four writes from each master, grants must alternate
        m0_if.we = 1; m0_if.addr = 32'h100; m0_if.wdata = 32'hA0; m0_if.req = 1;
        m1_if.we = 1; m1_if.addr = 32'h200; m1_if.wdata = 32'hB0; m1_if.req = 1;
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (!(m0_if.ack || m1_if.ack) && t < 20) begin
                step;
                t++;
            end
            chk("cont_ack_seen", 32'(t < 20), 1);
            exp_g = k[0];
            exp_a = exp_g ? 32'h200 : 32'h100;
            chk("cont_grant", grant, 32'(exp_g));
            chk("cont_ack0", m0_if.ack, 32'(!exp_g));
            chk("cont_ack1", m1_if.ack, 32'(exp_g));
            chk("cont_addr", addr, exp_a);
            if (k == 6) m0_if.req = 0;
            if (k == 7) m1_if.req = 0;
            step;
        end
        chk("cont_end_busy", busy, 0);

        // Late request: m1 rises while m0's read is in WAIT
        m0_if.we = 0; m0_if.addr = 32'h20; m0_if.req = 1;
        step;
        step;
        m1_if.we = 1; m1_if.addr = 32'h300; m1_if.wdata = 32'hCAFE; m1_if.req = 1;
        step;
        chk("late_ack0", m0_if.ack, 1);
        chk("late_ack1_early", m1_if.ack, 0);
        chk("late_rdata0", m0_if.rdata, mem_f(32'h20));
        m0_if.req = 0;
        step;
        chk("late_idle_busy", busy, 0);
        chk("late_idle_ack1", m1_if.ack, 0);
        step;
        chk("late_access_grant", grant, 1);
        chk("late_access_mwrite", mw, 1);
        chk("late_access_addr", addr, 32'h300);
        step;
        chk("late_done_ack1", m1_if.ack, 1);
        m1_if.req = 0;
        step;

        // Reset asserted during WAIT
        m0_if.we = 0; m0_if.addr = 32'h40; m0_if.req = 1;
        step;
        step;
        chk("rstw_busy_before", busy, 1);
        reset = 1;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_grant", grant, 0);
        chk("rstw_addr", addr, 0);
        chk("rstw_rdata0", m0_if.rdata, 0);
        chk("rstw_ack0", m0_if.ack, 0);
        step;
        chk("rstw_hold_ack0", m0_if.ack, 0);
        chk("rstw_hold_busy", busy, 0);
        reset = 0;
        step;
        chk("rstw_reissue_mread", mr, 1);
        chk("rstw_reissue_addr", addr, 32'h40);
        step;
        chk("rstw_reissue_wait_ack", m0_if.ack, 0);
        step;
        chk("rstw_reissue_ack", m0_if.ack, 1);
        chk("rstw_reissue_rdata", m0_if.rdata, mem_f(32'h40));
        m0_if.req = 0;
        step;

        // MEM_LATENCY = 0
        a0_if.we = 0; a0_if.addr = 32'h50; a0_if.req = 1;
        step;
        chk("l0_access_mread", z_mr, 1);
        chk("l0_access_ack", a0_if.ack, 0);
        step;
        chk("l0_done_ack", a0_if.ack, 1);
        chk("l0_done_rdata", a0_if.rdata, mem_f(32'h50));
        a0_if.req = 0;
        step;

        // MEM_LATENCY = 3
        b0_if.we = 0; b0_if.addr = 32'h60; b0_if.req = 1;
        step;
        chk("l3_access_mread", t_mr, 1);
        step;
        step;
        step;
        chk("l3_c4_ack", b0_if.ack, 0);
        chk("l3_c4_busy", t_busy, 1);
        step;
        chk("l3_c5_ack", b0_if.ack, 1);
        chk("l3_c5_rdata", b0_if.rdata, mem_f(32'h60));
        b0_if.req = 0;
        step;
        chk("l3_idle_busy", t_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
